// File: rtl/mmio_decoder_mux.sv
// MMIO address decoder and fan-out: one master, NSLV base/mask windows, with
// bus timeout, decode-error response and sticky error IRQ with fault address.
module mmio_decoder_mux #(
    parameter int unsigned           NSLV     = 8,
    parameter int unsigned           AW       = 32,
    parameter int unsigned           DW       = 32,
    parameter logic [NSLV*AW-1:0]    SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*AW-1:0]    SLV_MASK = {NSLV{32'hff000000}},
    parameter int unsigned           TIMEOUT  = 255,
    parameter logic [DW-1:0]         ERR_VAL  = 32'hdeadbeef
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        a,
    input  logic [DW-1:0]        d,
    input  logic                 we,
    input  logic                 rd,
    output logic [DW-1:0]        spo,
    output logic                 ready,
    output logic [AW-1:0]        s_a,
    output logic [DW-1:0]        s_d,
    output logic [NSLV-1:0]      s_we,
    output logic [NSLV-1:0]      s_rd,
    input  logic [NSLV*DW-1:0]   s_spo,
    input  logic [NSLV-1:0]      s_ready,
    output logic                 err_irq,
    output logic [AW-1:0]        err_addr,
    input  logic                 err_clr
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DEC,
        ISS,
        GRD,
        WT
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   a_q;
    logic [DW-1:0]   d_q;
    logic            we_q;
    logic            rd_q;
    logic [SW-1:0]   sel_q;
    logic [15:0]     cnt_q;
    logic [DW-1:0]   spo_q;
    logic [NSLV-1:0] s_we_q;
    logic [NSLV-1:0] s_rd_q;
    logic [AW-1:0]   s_a_q;
    logic [DW-1:0]   s_d_q;
    logic            err_irq_q;
    logic [AW-1:0]   err_addr_q;

    logic            hit_d;
    logic [SW-1:0]   sel_d;
    logic [AW-1:0]   win_mask_d;
    logic [NSLV-1:0] onehot_d;
    logic [DW-1:0]   slv_rdata;
    logic            slv_rdy;
    logic [15:0]     cnt_inc;
    logic            to_hit;
    logic            err_set;

    // Forward scan with a found flag so the lowest matching index wins.
    always_comb begin
        hit_d      = 1'b0;
        sel_d      = '0;
        win_mask_d = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!hit_d &&
                ((a_q & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
                hit_d      = 1'b1;
                sel_d      = SW'(i);
                win_mask_d = SLV_MASK[i*AW +: AW];
            end
        end
    end

    always_comb begin
        onehot_d = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            onehot_d[i] = (sel_d == SW'(i));
        end
    end

    always_comb begin
        slv_rdata = '0;
        slv_rdy   = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                slv_rdata = s_spo[i*DW +: DW];
                slv_rdy   = s_ready[i];
            end
        end
    end

    // Saturating increment; abort fires on the cycle the count would reach TIMEOUT.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        to_hit  = (TIMEOUT != 0) && (cnt_inc == 16'(TIMEOUT));
        err_set = ((state_q == DEC) && !hit_d) ||
                  ((state_q == WT) && !slv_rdy && to_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            d_q        <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            sel_q      <= '0;
            cnt_q      <= '0;
            spo_q      <= '0;
            s_we_q     <= '0;
            s_rd_q     <= '0;
            s_a_q      <= '0;
            s_d_q      <= '0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            s_we_q <= '0;
            s_rd_q <= '0;

            if (err_clr) begin
                err_irq_q <= 1'b0;
            end else if (err_set) begin
                err_irq_q <= 1'b1;
            end
            if (err_set && !err_irq_q) begin
                err_addr_q <= a_q;
            end

            case (state_q)
                IDLE: begin
                    if (we | rd) begin
                        a_q     <= a;
                        d_q     <= d;
                        we_q    <= we;
                        rd_q    <= rd & ~we;
                        state_q <= DEC;
                    end
                end
                DEC: begin
                    sel_q <= sel_d;
                    s_a_q <= a_q & ~win_mask_d;
                    s_d_q <= d_q;
                    if (hit_d) begin
                        s_we_q  <= we_q ? onehot_d : '0;
                        s_rd_q  <= rd_q ? onehot_d : '0;
                        state_q <= ISS;
                    end else begin
                        spo_q   <= ERR_VAL;
                        state_q <= IDLE;
                    end
                end
                ISS: begin
                    cnt_q   <= '0;
                    state_q <= GRD;
                end
                GRD: begin
                    state_q <= WT;
                end
                WT: begin
                    if (slv_rdy) begin
                        spo_q   <= slv_rdata;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (to_hit) begin
                            spo_q   <= ERR_VAL;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready    = (state_q == IDLE) && !(we | rd);
    assign spo      = spo_q;
    assign s_a      = s_a_q;
    assign s_d      = s_d_q;
    assign s_we     = s_we_q;
    assign s_rd     = s_rd_q;
    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mmio_decoder_mux.sv
// Directed bench for mmio_decoder_mux: 4 slaves, TIMEOUT=20, cycle-exact checks.
module tb_mmio_decoder_mux;

    localparam int unsigned NSLV = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    // slot 3 first: 0x98/0xf0 (overlaps 0x9b), 0x93, 0x91, 0x9b
    localparam logic [NSLV*AW-1:0] BASE = {32'h98000000, 32'h93000000, 32'h91000000, 32'h9b000000};
    localparam logic [NSLV*AW-1:0] MASK = {32'hf0000000, 32'hff000000, 32'hff000000, 32'hff000000};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic            we, rd;
    logic [DW-1:0]   spo;
    logic            ready;
    logic [AW-1:0]   s_a;
    logic [DW-1:0]   s_d;
    logic [NSLV-1:0] s_we, s_rd;
    logic [DW-1:0]   spo1;
    logic [NSLV*DW-1:0] s_spo;
    logic [NSLV-1:0] s_ready;
    logic            err_irq;
    logic [AW-1:0]   err_addr;
    logic            err_clr;

    int n_chk = 0;
    int n_fail = 0;

    assign s_spo = {32'h00003333, 32'h00002222, spo1, 32'ha0a00000};

    always #5 clk = ~clk;

    mmio_decoder_mux #(
        .NSLV(NSLV), .AW(AW), .DW(DW),
        .SLV_BASE(BASE), .SLV_MASK(MASK),
        .TIMEOUT(20), .ERR_VAL(32'hdeadbeef)
    ) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .s_a(s_a), .s_d(s_d),
        .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .err_irq(err_irq), .err_addr(err_addr), .err_clr(err_clr)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycle 0: strobe presented at this negedge, cleared at the next one.
    task automatic strobe(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic w, input logic r);
        @(negedge clk);
        a = addr; d = data; we = w; rd = r;
        #1;
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop: got %b want 0", ready); end
        @(negedge clk);
        we = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a = '0; d = '0; we = 0; rd = 0; err_clr = 0;
        s_ready = 4'b1111; spo1 = 32'h0;
        cyc(2);
        n_chk++;
        if ({spo, s_a, s_d, err_addr} !== '0) begin n_fail++;
            $display("FAIL reset_regs: got spo=%h s_a=%h s_d=%h err_addr=%h want all 0", spo, s_a, s_d, err_addr); end
        n_chk++;
        if ({s_we, s_rd, err_irq, ready} !== 10'b0000_0000_01) begin n_fail++;
            $display("FAIL reset_ctl: got we=%b rd=%b irq=%b rdy=%b want 0000 0000 0 1", s_we, s_rd, err_irq, ready); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_write_hit;
        strobe(32'h93000008, 32'h55, 1'b1, 1'b0);           // now cycle 1
        n_chk++;
        if (s_we !== 4'b0000) begin n_fail++; $display("FAIL wr_c1_swe: got %b want 0000", s_we); end
        cyc(1);                                              // cycle 2
        n_chk++;
        if (s_we !== 4'b0100 || s_rd !== 4'b0000) begin n_fail++;
            $display("FAIL wr_c2_strobe: got we=%b rd=%b want 0100 0000", s_we, s_rd); end
        n_chk++;
        if (s_a !== 32'h8 || s_d !== 32'h55) begin n_fail++;
            $display("FAIL wr_addr_data: got s_a=%h s_d=%h want 8 55", s_a, s_d); end
        cyc(1);                                              // cycle 3
        n_chk++;
        if (s_we !== 4'b0000) begin n_fail++; $display("FAIL wr_c3_swe: got %b want 0000", s_we); end
        cyc(1);                                              // cycle 4
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL wr_c4_ready: got %b want 0", ready); end
        cyc(1);                                              // cycle 5
        n_chk++;
        if (ready !== 1'b1 || spo !== 32'h2222) begin n_fail++;
            $display("FAIL wr_c5_done: got ready=%b spo=%h want 1 2222", ready, spo); end
    endtask

    task automatic test_slow_read;
        strobe(32'h91000040, 32'h0, 1'b0, 1'b1);            // cycle 1
        cyc(1);                                              // cycle 2
        n_chk++;
        if (s_rd !== 4'b0010 || s_a !== 32'h40) begin n_fail++;
            $display("FAIL slow_strobe: got s_rd=%b s_a=%h want 0010 40", s_rd, s_a); end
        s_ready[1] = 1'b0;
        cyc(10);                                             // cycle 12
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL slow_wait: got ready=%b want 0", ready); end
        s_ready[1] = 1'b1; spo1 = 32'h1234;
        cyc(1);                                              // cycle 13
        n_chk++;
        if (ready !== 1'b1 || spo !== 32'h1234 || err_irq !== 1'b0) begin n_fail++;
            $display("FAIL slow_done: got ready=%b spo=%h irq=%b want 1 1234 0", ready, spo, err_irq); end
    endtask

    task automatic test_unmapped;
        strobe(32'h50000000, 32'h0, 1'b0, 1'b1);            // cycle 1
        n_chk++;
        if (ready !== 1'b0 || s_rd !== 4'b0000) begin n_fail++;
            $display("FAIL unm_c1: got ready=%b s_rd=%b want 0 0000", ready, s_rd); end
        cyc(1);                                              // cycle 2
        n_chk++;
        if (ready !== 1'b1 || spo !== 32'hdeadbeef) begin n_fail++;
            $display("FAIL unm_c2: got ready=%b spo=%h want 1 deadbeef", ready, spo); end
        n_chk++;
        if (s_rd !== 4'b0000 || s_we !== 4'b0000) begin n_fail++;
            $display("FAIL unm_nostrobe: got s_rd=%b s_we=%b want 0000 0000", s_rd, s_we); end
        n_chk++;
        if (err_irq !== 1'b1 || err_addr !== 32'h50000000) begin n_fail++;
            $display("FAIL unm_err: got irq=%b addr=%h want 1 50000000", err_irq, err_addr); end
    endtask

    task automatic test_timeout;
        s_ready[0] = 1'b0;
        strobe(32'h9b000004, 32'h0, 1'b0, 1'b1);            // cycle 1
        cyc(22);                                             // cycle 23
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL to_c23: got ready=%b want 0", ready); end
        cyc(1);                                              // cycle 24
        n_chk++;
        if (ready !== 1'b1 || spo !== 32'hdeadbeef) begin n_fail++;
            $display("FAIL to_c24: got ready=%b spo=%h want 1 deadbeef", ready, spo); end
        n_chk++;
        if (err_irq !== 1'b1 || err_addr !== 32'h50000000) begin n_fail++;
            $display("FAIL to_sticky: got irq=%b addr=%h want 1 50000000", err_irq, err_addr); end
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        n_chk++;
        if (err_irq !== 1'b0) begin n_fail++; $display("FAIL err_clr: got irq=%b want 0", err_irq); end
        s_ready[0] = 1'b1;
    endtask

    task automatic test_priority;
        strobe(32'h9b000010, 32'h0, 1'b0, 1'b1);
        cyc(1);                                              // cycle 2
        n_chk++;
        if (s_rd !== 4'b0001 || s_a !== 32'h10) begin n_fail++;
            $display("FAIL ovl_strobe: got s_rd=%b s_a=%h want 0001 10", s_rd, s_a); end
        cyc(3);                                              // cycle 5
        n_chk++;
        if (ready !== 1'b1 || spo !== 32'ha0a00000) begin n_fail++;
            $display("FAIL ovl_done: got ready=%b spo=%h want 1 a0a00000", ready, spo); end
        strobe(32'h93000000, 32'h99, 1'b1, 1'b1);
        cyc(1);                                              // cycle 2
        n_chk++;
        if (s_we !== 4'b0100 || s_rd !== 4'b0000) begin n_fail++;
            $display("FAIL wr_wins: got s_we=%b s_rd=%b want 0100 0000", s_we, s_rd); end
        cyc(3);
    endtask

    task automatic test_reset_mid;
        err_clr = 1'b1;                                      // make err_addr distinct from reset? keep 5000_0000
        err_clr = 1'b0;
        s_ready[0] = 1'b0;
        strobe(32'h9b000004, 32'h0, 1'b0, 1'b1);            // cycle 1
        cyc(5);                                              // cycle 6
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({spo, s_a, err_addr} !== '0 || s_rd !== 4'b0000 || ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid: got spo=%h s_a=%h addr=%h s_rd=%b ready=%b want 0 0 0 0000 1",
                     spo, s_a, err_addr, s_rd, ready); end
        cyc(2);
        rst_n = 1'b1;
        s_ready = 4'b1111;
        cyc(2);
        n_chk++;
        if (s_rd !== 4'b0000 || s_we !== 4'b0000 || ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_noreissue: got s_rd=%b s_we=%b ready=%b want 0000 0000 1", s_rd, s_we, ready); end
        strobe(32'h93000020, 32'h77, 1'b1, 1'b0);
        cyc(1);                                              // cycle 2
        n_chk++;
        if (s_we !== 4'b0100 || s_d !== 32'h77 || s_a !== 32'h20) begin n_fail++;
            $display("FAIL rst_wr_strobe: got s_we=%b s_d=%h s_a=%h want 0100 77 20", s_we, s_d, s_a); end
        cyc(3);                                              // cycle 5
        n_chk++;
        if (ready !== 1'b1 || spo !== 32'h2222) begin n_fail++;
            $display("FAIL rst_wr_done: got ready=%b spo=%h want 1 2222", ready, spo); end
    endtask

    initial begin
        test_reset;
        test_write_hit;
        test_slow_read;
        test_unmapped;
        test_timeout;
        test_priority;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_decoder_mux.md
# mmio_decoder_mux

Parametrised successor to the fixed low-speed MMIO mapper: one master port fanned out to `NSLV` slaves, selected by per-slave base/mask address windows set in parameters. Each transaction is latched, decoded, strobed to one slave and completed on that slave's ready. Adds a bus timeout, a decode-error response and a sticky error/IRQ with a captured fault address. Sits between the CPU/MMU data port and the MMIO peripherals: gpio, uart, sd, usb, interrupt unit, serialboot, timer, eth, and so on.

## Interface
- `NSLV`, 8: number of slave ports, 1..16.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `SLV_BASE`, {NSLV{32'h0}}: packed `NSLV*AW`; slot i is the base address of slave i.
- `SLV_MASK`, {NSLV{32'hff000000}}: packed `NSLV*AW`; slot i marks the address bits compared for slave i.
- `TIMEOUT`, 255: wait cycles before abort, 1..65535; 0 disables the timeout.
- `ERR_VAL`, 32'hdeadbeef: read data returned on a decode error or timeout.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a` in AW: master address.
- `d` in DW: master write data.
- `we` in 1: master write strobe, one-cycle pulse.
- `rd` in 1: master read strobe, one-cycle pulse.
- `spo` out DW: registered read data.
- `ready` out 1: high when idle and no strobe is present.
- `s_a` out AW: shared slave address, `a_r & ~SLV_MASK[sel]` (offset within the window).
- `s_d` out DW: shared slave write data, `d_r`.
- `s_we` out NSLV: per-slave write strobe, one-hot, registered.
- `s_rd` out NSLV: per-slave read strobe, one-hot, registered.
- `s_spo` in NSLV*DW: packed slave read data.
- `s_ready` in NSLV: per-slave ready.
- `err_irq` out 1: sticky error, level.
- `err_addr` out AW: address of the first unacknowledged fault.
- `err_clr` in 1: pulse; clears `err_irq` and re-arms `err_addr` capture.

## Operation
- Decode: slave i matches when `(a_r & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i])`. When several slaves match, the lowest index wins. When none match, it is a decode error.
- If `we` and `rd` are asserted together, the write wins; `rd_r` is latched as 0.
- Strobes arriving while `state != IDLE` are ignored. Masters must wait for `ready`.
- State machine:
  - IDLE: on `we|rd`, latch `a`/`d`/`we`/`rd` into `a_r`/`d_r`/`we_r`/`rd_r`, then go to DEC.
  - DEC: register `sel` and `hit`. On a hit, go to ISS. On a miss, load `spo=ERR_VAL`, set the error, go to IDLE.
  - ISS: `s_we[sel]=we_r` and `s_rd[sel]=rd_r` for exactly one cycle. Clear the timeout counter. Go to GRD.
  - GRD: `s_ready` is ignored here, giving slaves one cycle to drop ready. Go to WT.
  - WT: if `s_ready[sel]`, capture `spo=s_spo[sel]` (reads and writes alike) and go to IDLE. Otherwise increment the counter. When the counter reaches `TIMEOUT`, load `spo=ERR_VAL`, set the error, and go to IDLE.
- Error set: `err_irq<=1`. `err_addr<=a_r` only when `err_irq` was 0, so the first fault is kept.
- `err_clr` has priority over a set in the same cycle: the bit is cleared, and the new fault is captured with `err_irq=0`, so it is lost. This is the documented behaviour.
- `s_a`/`s_d` stay stable from DEC until the next latch.
- Non-selected `s_we`/`s_rd` bits are always 0.
- The timeout counter is 16 bits and saturates. It never wraps.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE
  - `spo`=0, `s_we`=0, `s_rd`=0, `s_a`=0, `s_d`=0
  - `err_irq`=0, `err_addr`=0
  - counter 0, `ready`=1 (combinational: `state==IDLE & !(we|rd)`)
- Edge numbering: strobe in cycle 0, latched at edge 0.
  - DEC during cycle 1.
  - ISS during cycle 2, slave strobe high.
  - GRD during cycle 3.
  - WT from cycle 4.
- Minimum hit latency: `s_ready` high in cycle 4 gives `ready`=1 and valid `spo` in cycle 5, i.e. 5 cycles.
- Decode error: `ready`=1 and `spo=ERR_VAL` in cycle 2.
- Timeout with `TIMEOUT=N`: `ready` returns in cycle 4+N.
- Reset deassertion mid-transaction: the next transaction starts clean and no strobe is re-issued. A slave holding a pending operation is the slave's responsibility.
- `ready` drops combinationally in the same cycle the master asserts a strobe.

## Test plan
- Write hit: `NSLV`=4, slave 2 window 0x93000000/0xff000000, `we` to 0x93000008 with d=0x55. Required: `s_we`=4'b0100 only in cycle 2; `s_a`=0x8; `s_d`=0x55; with `s_ready[2]` held high, `ready` rises in cycle 5.
- Read with slow slave: slave 1 drops `s_ready` for 10 cycles after `s_rd`, then raises it with `s_spo`=0x1234. Required: `spo`=0x1234; `ready` rises the cycle after `s_ready[1]` is seen; `err_irq`=0.
- Unmapped read of 0x50000000. Required: `spo`=0xdeadbeef and `ready`=1 in cycle 2; no slave strobes; `err_irq`=1; `err_addr`=0x50000000.
- Timeout: `TIMEOUT`=20, selected slave never readies. Required: `ready` in cycle 24 with `spo`=`ERR_VAL`. A second fault leaves `err_addr` unchanged. `err_clr` drops `err_irq`.
- Overlap and priority: slaves 0 and 3 both match 0x9b000000. Required: only `s_rd[0]` pulses. Simultaneous `we`+`rd`: only `s_we` pulses.
- Reset mid-WT: drop `rst_n` in cycle 6 of a pending read. Required: outputs return to reset values immediately. After release, the next write completes normally.
